// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined two's-complement adder/subtractor with a valid/ready stream
//   interface. The WIDTH-bit carry chain is cut into STAGES equal slices of
//   S = WIDTH/STAGES bits. Slice k is resolved in stage k from the carry
//   registered by stage k-1, so the longest combinational path is one S-bit
//   adder. One operation is accepted per cycle; a single global stall freezes
//   the whole pipeline while the consumer is not ready.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth and number of carry-chain slices
//           (1 <= STAGES <= WIDTH, WIDTH % STAGES == 0)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   beat can be accepted this cycle
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat present
//   out_ready  consumer accepts result this cycle
//   sum        result modulo 2^WIDTH
//   cout       carry-out of MSB (sub: 1 = no borrow)
//   overflow   signed overflow of the operation
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_addsub: illegal WIDTH/STAGES combination");
  end

  localparam int unsigned S    = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  // Per-stage state. acc holds the resolved sum in its completed low slices
  // and operand A (skew) in the slices still to be computed; bop holds the
  // effective B operand. Its MSB is the B sign used for overflow, so only
  // the A sign needs a dedicated register (acc's MSB is overwritten by the
  // last slice).
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [STAGES-1:0] sa_q,  sa_d;
  word_t             acc_q [STAGES];
  word_t             acc_d [STAGES];
  word_t             bop_q [STAGES];
  word_t             bop_d [STAGES];

  // Stage inputs: stage 0 takes the input beat, stage k takes stage k-1.
  word_t             acc_in [STAGES];
  logic [STAGES-1:0] cry_in;
  logic [S:0]        slc    [STAGES];

  word_t b_eff;
  logic  advance;

  assign advance  = !vld_q[LAST] || out_ready;
  assign in_ready = advance && !rst;

  always_comb begin : stage_inputs
    b_eff     = sub ? ~b : b;
    vld_d     = '0;
    cry_in    = '0;
    sa_d      = '0;
    acc_in[0] = a;
    bop_d[0]  = b_eff;
    cry_in[0] = sub ? ~cin : cin;
    sa_d[0]   = a[WIDTH-1];
    vld_d[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      acc_in[k] = acc_q[k-1];
      bop_d[k]  = bop_q[k-1];
      cry_in[k] = cry_q[k-1];
      sa_d[k]   = sa_q[k-1];
      vld_d[k]  = vld_q[k-1];
    end
  end

  // Each stage resolves exactly one S-bit slice and forwards everything else.
  always_comb begin : slice_add
    cry_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      slc[k] = {1'b0, acc_in[k][k*S +: S]}
             + {1'b0, bop_d[k][k*S +: S]}
             + {{S{1'b0}}, cry_in[k]};
      acc_d[k]             = acc_in[k];
      acc_d[k][k*S +: S]   = slc[k][S-1:0];
      cry_d[k]             = slc[k][S];
    end
  end

  // Global stall: nothing moves unless the output slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cry_q <= '0;
      sa_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      sa_q  <= sa_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        bop_q[k] <= bop_d[k];
      end
    end
  end

  always_comb begin : outputs
    out_valid = vld_q[LAST];
    sum       = acc_q[LAST];
    cout      = cry_q[LAST];
    overflow  = (sa_q[LAST] == bop_q[LAST][WIDTH-1]) && (acc_q[LAST][WIDTH-1] != sa_q[LAST]);
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface; the multi-cycle successor of the team's 32-bit ripple-carry adder. The WIDTH-bit carry chain is split into STAGES equal slices, and each slice is registered so the critical path is WIDTH/STAGES full-adder cells. It adds carry-in, subtract mode, carry-out, signed overflow and backpressure. It sits between operand-producing logic and any consumer that may stall, and accepts one operation per cycle.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- STAGES, 4, pipeline depth and number of carry-chain slices; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES == 0 (elaboration error otherwise).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a + b + cin; 1: a − b − cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out of MSB (sub: 1 = no borrow).
- overflow  out  1  signed overflow of the operation.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Result = a + b_eff + c0 over WIDTH+1 bits; sum = low WIDTH bits; cout = bit WIDTH.
- overflow = (a[WIDTH−1] == b_eff[WIDTH−1]) && (sum[WIDTH−1] != a[WIDTH−1]).
- Slice k (k = 0..STAGES−1) covers bits [k·S +: S], S = WIDTH/STAGES, and is computed in stage k from the carry registered by stage k−1 (stage 0 uses c0).
- Operand bits of not-yet-computed slices are carried forward in skew registers; result bits of completed slices are carried forward to the output. MSB operand signs travel with the beat for the overflow computation in the last stage.
- Each stage holds a valid bit. Global stall: advance = !out_valid || out_ready. When advance = 1, every stage loads from its predecessor and stage 0 loads the input beat, with valid = in_valid.
- in_ready = advance && !rst (combinational from out_valid, out_ready, rst).
- Bubbles propagate as invalid stages; they are not compacted while stalled. Stall is global.
- STAGES == 1: single registered WIDTH-bit add; same handshake.

## Timing
- Reset (rst high at an edge): all stage valid bits, carries, skew and result registers clear to 0. After reset: out_valid=0, sum=0, cout=0, overflow=0, and in_ready=1 once rst is low.
- Reset mid-operation discards all in-flight beats. No beat accepted in a reset cycle appears at the output.
- Input transfer: edge where in_valid && in_ready. Output transfer: edge where out_valid && out_ready.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES−1, when no stall occurs.
- Throughput: 1 beat/cycle with out_ready held high.
- While out_valid && !out_ready: sum/cout/overflow/out_valid are held stable, in_ready=0, and no internal state changes.
- Simultaneous output transfer and input transfer in the same cycle is allowed (full-rate flow-through).
- Results leave in acceptance order; no beat is dropped or duplicated.
- Wrap-around: sum is modulo 2^WIDTH. Carry beyond bit WIDTH appears only on cout.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> 4 cycles later sum=0x0000_0000, cout=1, overflow=0 (carry crosses all slice boundaries).
- a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, cout=0, overflow=1. Then a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, overflow=0.
- Sub with borrow-in: a=0x10, b=0x01, sub=1, cin=1 -> sum=0x0E, cout=1. Back-to-back stream of 100 random beats with random sub/cin -> outputs match a golden model in order, one per cycle, first result at cycle 4.
- Backpressure: send 6 beats, deassert out_ready for 3 cycles while out_valid=1 -> in_ready=0 throughout, outputs stable, all 6 results delivered in order with no loss or duplication.
- Reset while 3 beats are in flight -> out_valid=0 after the reset edge, and none of the 3 results ever appears; the next accepted beat emerges with the normal 4-cycle latency.
- Parameter sweep (WIDTH, STAGES) ∈ {(8,1), (8,8), (16,2), (64,4)}: exhaustive (8-bit) or random operands -> correct sum/cout/overflow with latency = STAGES.
